trap_dump_unit: RTL and testbench

- Hardware end of the halt-and-dump protocol for the pipelined DLX core.
- Watches the decode-stage instruction for the end-of-program trap (TRAP 0x300, encoding 0x44000300).
- On that trap it freezes the pipeline and reads the data-memory window 0x2000..0x20FC word by word.
- Each big-endian word is streamed out with its address over a valid/ready port to a debug or UART transmitter.

---
 rtl/trap_dump_unit.sv | 121 ++++++++++++
 tb/tb_trap_dump_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_dump_unit.sv
//------------------------------------------------------------------------------
// trap_dump_unit: halts the DLX pipeline on TRAP 0x300 and streams the
// data-memory dump window out as (address, big-endian word) beats.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module trap_dump_unit #(
  parameter logic [31:0] DUMP_BASE = 32'h0000_2000,
  parameter logic [31:0] DUMP_END  = 32'h0000_2100,
  parameter logic [31:0] TRAP_WORD = 32'h4400_0300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  output logic        halt_o,
  output logic        mem_rd_en_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic [31:0] dump_addr_o,
  output logic [31:0] dump_data_o,
  output logic        dump_last_o,
  output logic        done_o
);

  localparam logic [31:0] LAST_ADDR = DUMP_END - 32'd4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] addr_q, addr_d;

  logic        is_last;
  logic        trap_hit;

  assign is_last  = (addr_q == LAST_ADDR);
  assign trap_hit = instr_valid_i && (instr_i == TRAP_WORD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cur_addr_q <= 32'd0;
      mem_addr_q <= 32'd0;
      data_q     <= 32'd0;
      addr_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      mem_addr_q <= mem_addr_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
    end
  end

  // mem_addr is loaded on entry to RD so it matches cur_addr there and holds afterwards
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    mem_addr_d = mem_addr_q;
    data_d     = data_q;
    addr_d     = addr_q;
    case (state_q)
      S_IDLE: begin
        if (trap_hit) begin
          cur_addr_d = DUMP_BASE;
          mem_addr_d = DUMP_BASE;
          state_d    = S_RD;
        end
      end
      S_RD: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        data_d  = mem_rdata_i;
        addr_d  = cur_addr_q;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (dump_ready_i) begin
          if (is_last) begin
            state_d = S_DONE;
          end else begin
            cur_addr_d = cur_addr_q + 32'd4;
            mem_addr_d = cur_addr_q + 32'd4;
            state_d    = S_RD;
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign halt_o       = (state_q != S_IDLE);
  assign mem_rd_en_o  = (state_q == S_RD);
  assign mem_addr_o   = mem_addr_q;
  assign dump_valid_o = (state_q == S_SEND);
  assign dump_addr_o  = addr_q;
  assign dump_data_o  = data_q;
  assign dump_last_o  = (state_q == S_SEND) && is_last;
  assign done_o       = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_trap_dump_unit.sv
//------------------------------------------------------------------------------
// tb_trap_dump_unit: directed vectors plus hand-written dump sequences.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_trap_dump_unit;

  localparam logic [31:0] TRAP = 32'h4400_0300;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        halt;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_addr;
  logic [31:0] dump_data;
  logic        dump_last;
  logic        done;

  int checks = 0;
  int fails  = 0;

  logic [7:0] mem [0:255];

  trap_dump_unit dut (
    .clk          (clk),
    .rst          (rst),
    .instr_i      (instr),
    .instr_valid_i(instr_valid),
    .halt_o       (halt),
    .mem_rd_en_o  (mem_rd_en),
    .mem_addr_o   (mem_addr),
    .mem_rdata_i  (mem_rdata),
    .dump_valid_o (dump_valid),
    .dump_ready_i (dump_ready),
    .dump_addr_o  (dump_addr),
    .dump_data_o  (dump_data),
    .dump_last_o  (dump_last),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data appears the cycle after the read request
  always @(posedge clk) begin
    if (mem_rd_en) begin
      if (mem_addr >= 32'h2000 && mem_addr < 32'h2100)
        mem_rdata <= {mem[mem_addr - 32'h2000], mem[mem_addr - 32'h1fff],
                      mem[mem_addr - 32'h1ffe], mem[mem_addr - 32'h1ffd]};
      else
        mem_rdata <= 32'd0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_sweep();
    for (int a = 0; a < 256; a += 4) begin
      logic [31:0] w;
      w = 32'h2000 + a;
      mem[a]   = w[31:24];
      mem[a+1] = w[23:16];
      mem[a+2] = w[15:8];
      mem[a+3] = w[7:0];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr = 32'd0;
    instr_valid = 1'b0;
    dump_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Presents one instruction for one edge (edge T); returns in cycle T+1
  task automatic present(input logic [31:0] w, input logic v);
    instr = w;
    instr_valid = v;
    tick();
    instr = 32'd0;
    instr_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] w;
    logic        v;
    logic        exp_halt;
  } vec_t;

  vec_t vecs [5];

  initial begin
    mem_rdata = 32'd0;
    fill_sweep();

    vecs[0] = '{w: TRAP,          v: 1'b1, exp_halt: 1'b1};
    vecs[1] = '{w: TRAP,          v: 1'b0, exp_halt: 1'b0};
    vecs[2] = '{w: 32'h4400_0301, v: 1'b1, exp_halt: 1'b0};
    vecs[3] = '{w: 32'h0000_0300, v: 1'b1, exp_halt: 1'b0};
    vecs[4] = '{w: 32'hC400_0300, v: 1'b1, exp_halt: 1'b0};

    // Reset state
    do_reset();
    check("rst_halt", {31'd0, halt}, 32'd0);
    check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_valid", {31'd0, dump_valid}, 32'd0);
    check("rst_daddr", dump_addr, 32'd0);
    check("rst_ddata", dump_data, 32'd0);
    check("rst_last", {31'd0, dump_last}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);

    // Trigger decode table
    for (int i = 0; i < 5; i++) begin
      do_reset();
      present(vecs[i].w, vecs[i].v);
      check($sformatf("vec%0d_halt", i), {31'd0, halt}, {31'd0, vecs[i].exp_halt});
      check($sformatf("vec%0d_rd_en", i), {31'd0, mem_rd_en}, {31'd0, vecs[i].exp_halt});
      tick();
      tick();
      check($sformatf("vec%0d_halt_later", i), {31'd0, halt}, {31'd0, vecs[i].exp_halt});
    end

    // Normal trigger with DEADBEEF at the base
    do_reset();
    mem[0] = 8'hDE; mem[1] = 8'hAD; mem[2] = 8'hBE; mem[3] = 8'hEF;
    present(TRAP, 1'b1);
    check("norm_halt_T1", {31'd0, halt}, 32'd1);
    check("norm_rd_en_T1", {31'd0, mem_rd_en}, 32'd1);
    check("norm_mem_addr_T1", mem_addr, 32'h2000);
    tick();
    check("norm_valid_T2", {31'd0, dump_valid}, 32'd0);
    tick();
    check("norm_valid_T3", {31'd0, dump_valid}, 32'd1);
    check("norm_daddr_T3", dump_addr, 32'h2000);
    check("norm_ddata_T3", dump_data, 32'hDEADBEEF);
    check("norm_last_T3", {31'd0, dump_last}, 32'd0);
    fill_sweep();

    // Full sweep with ready high; then sticky done
    do_reset();
    present(TRAP, 1'b1);
    begin
      int beats;
      int lasts;
      beats = 0;
      lasts = 0;
      for (int c = 1; c <= 200; c++) begin
        if (dump_valid) begin
          check("sweep_cycle", c, 3 + 3 * beats);
          check("sweep_addr", dump_addr, 32'h2000 + 4 * beats);
          check("sweep_data", dump_data, 32'h2000 + 4 * beats);
          check("sweep_last", {31'd0, dump_last}, {31'd0, beats == 63});
          if (dump_last) lasts++;
          beats++;
        end
        if (c == 192 || c == 193)
          check($sformatf("sweep_done_c%0d", c), {31'd0, done}, {31'd0, c >= 193});
        check("sweep_halt", {31'd0, halt}, 32'd1);
        tick();
      end
      check("sweep_beats", beats, 64);
      check("sweep_lasts", lasts, 1);
    end
    present(TRAP, 1'b1);
    for (int c = 0; c < 10; c++) begin
      check("sticky_done", {31'd0, done}, 32'd1);
      check("sticky_halt", {31'd0, halt}, 32'd1);
      check("sticky_valid", {31'd0, dump_valid}, 32'd0);
      check("sticky_rd_en", {31'd0, mem_rd_en}, 32'd0);
      tick();
    end

    // Backpressure on the word at 0x2004
    do_reset();
    present(TRAP, 1'b1);
    tick();
    tick();
    check("bp_w0_addr", dump_addr, 32'h2000);
    tick();
    dump_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, dump_valid}, 32'd1);
      check("bp_addr", dump_addr, 32'h2004);
      check("bp_data", dump_data, 32'h2004);
      check("bp_rd_en", {31'd0, mem_rd_en}, 32'd0);
      tick();
    end
    check("bp_still_valid", {31'd0, dump_valid}, 32'd1);
    dump_ready = 1'b1;
    tick();
    check("bp_after_valid", {31'd0, dump_valid}, 32'd0);
    check("bp_after_rd_en", {31'd0, mem_rd_en}, 32'd1);
    check("bp_after_mem_addr", mem_addr, 32'h2008);

    // Reset while sending 0x2010, then restart
    do_reset();
    present(TRAP, 1'b1);
    for (int i = 1; i < 15; i++) tick();
    check("mid_valid", {31'd0, dump_valid}, 32'd1);
    check("mid_addr", dump_addr, 32'h2010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_halt", {31'd0, halt}, 32'd0);
    check("mid_rst_valid", {31'd0, dump_valid}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_last", {31'd0, dump_last}, 32'd0);
    check("mid_rst_daddr", dump_addr, 32'd0);
    present(TRAP, 1'b1);
    check("restart_mem_addr", mem_addr, 32'h2000);
    check("restart_rd_en", {31'd0, mem_rd_en}, 32'd1);
    tick();
    tick();
    check("restart_daddr", dump_addr, 32'h2000);
    check("restart_valid", {31'd0, dump_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
